qbus_reset_seq: RTL and testbench

//   Parametrised board reset and power sequencer for the Q-bus CPU tops.

---
 rtl/qbus_reset_seq.sv | 176 +++++++++++++++++
 tb/tb_qbus_reset_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/qbus_reset_seq.sv
// Board reset and power sequencer for the Q-bus CPU tops: button debounce plus the
// sys_rst_n -> DCLO -> ACLO power-up order and the ACLO -> DCLO power-fail order.
module qbus_reset_seq #(
   parameter int NBTN      = 3,
   parameter int RST_IDX   = 2,
   parameter int PF_IDX    = 1,
   parameter int DB_W      = 16,
   parameter int TW        = 16,
   parameter int SYS_DLY   = 255,
   parameter int DCLO_DLY  = 1000,
   parameter int ACLO_DLY  = 1000,
   parameter int PFAIL_DLY = 1000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NBTN-1:0] btn_n,
   output logic [NBTN-1:0] btn_q,
   output logic [NBTN-1:0] btn_p,
   output logic            sys_rst_n,
   output logic            dclo_n,
   output logic            aclo_n,
   output logic            seq_busy,
   output logic [2:0]      seq_state
);

   typedef enum logic [2:0] {
      POR = 3'd0,
      SYS = 3'd1,
      DCL = 3'd2,
      RUN = 3'd3,
      ACL = 3'd4
   } state_t;

   // Debounce toggles on the clock where the count would reach DB_MAX.
   localparam logic [DB_W-1:0] DB_LAST    = DB_W'((2 ** DB_W) - 2);
   localparam logic [TW-1:0]   SYS_LAST   = TW'(SYS_DLY - 1);
   localparam logic [TW-1:0]   DCLO_LAST  = TW'(DCLO_DLY - 1);
   localparam logic [TW-1:0]   ACLO_LAST  = TW'(ACLO_DLY - 1);
   localparam logic [TW-1:0]   PFAIL_LAST = TW'(PFAIL_DLY - 1);

   logic [NBTN-1:0] sync1, sync2, q_nxt;
   logic [DB_W-1:0] db_cnt  [NBTN];
   logic [DB_W-1:0] cnt_nxt [NBTN];

   always_comb begin
      for (int i = 0; i < NBTN; i++) begin
         q_nxt[i]   = btn_q[i];
         cnt_nxt[i] = db_cnt[i] + DB_W'(1);
         if (sync2[i] == ~btn_q[i]) begin
            cnt_nxt[i] = '0;
         end else if (db_cnt[i] == DB_LAST) begin
            q_nxt[i]   = ~btn_q[i];
            cnt_nxt[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
         btn_q <= '0;
         btn_p <= '0;
         for (int i = 0; i < NBTN; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         btn_q <= q_nxt;
         btn_p <= q_nxt & ~btn_q;
         for (int i = 0; i < NBTN; i++) db_cnt[i] <= cnt_nxt[i];
      end
   end

   state_t          state, nxt;
   logic [TW-1:0]   timer, tmr_nxt;
   logic            rst_req, req_nxt;
   logic            rst_btn, pf_btn;

   assign rst_btn = btn_q[RST_IDX];
   assign pf_btn  = btn_q[PF_IDX];

   function automatic logic [2:0] pins(input state_t s);
      case (s)
         SYS:      pins = 3'b100;
         DCL, ACL: pins = 3'b110;
         RUN:      pins = 3'b111;
         default:  pins = 3'b000;
      endcase
   endfunction

   // A held button parks POR with the timer cleared, so release restarts the full delay;
   // DCL and ACL instead park at expiry so they leave on the first clock the button is up.
   always_comb begin
      nxt     = state;
      tmr_nxt = timer + TW'(1);
      req_nxt = rst_req;
      case (state)
         POR: begin
            if (rst_btn) begin
               tmr_nxt = '0;
            end else if (timer == SYS_LAST) begin
               nxt     = SYS;
               tmr_nxt = '0;
            end
         end
         SYS: begin
            if (rst_btn) begin
               nxt     = POR;
               tmr_nxt = '0;
            end else if (timer == DCLO_LAST) begin
               nxt     = DCL;
               tmr_nxt = '0;
            end
         end
         DCL: begin
            if (rst_btn) begin
               nxt     = POR;
               tmr_nxt = '0;
            end else if (timer == ACLO_LAST) begin
               tmr_nxt = timer;
               if (!pf_btn) begin
                  nxt     = RUN;
                  tmr_nxt = '0;
               end
            end
         end
         RUN: begin
            if (rst_btn || pf_btn) begin
               nxt     = ACL;
               tmr_nxt = '0;
               req_nxt = rst_btn;
            end
         end
         ACL: begin
            if (rst_btn) req_nxt = 1'b1;
            if (timer == PFAIL_LAST) begin
               tmr_nxt = timer;
               if (rst_req || rst_btn) begin
                  nxt     = POR;
                  tmr_nxt = '0;
                  req_nxt = 1'b0;
               end else if (!pf_btn) begin
                  nxt     = DCL;
                  tmr_nxt = '0;
               end
            end
         end
         default: begin
            nxt     = POR;
            tmr_nxt = '0;
            req_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= POR;
         timer     <= '0;
         rst_req   <= 1'b0;
         sys_rst_n <= 1'b0;
         dclo_n    <= 1'b0;
         aclo_n    <= 1'b0;
         seq_busy  <= 1'b1;
         seq_state <= 3'd0;
      end else begin
         state                        <= nxt;
         timer                        <= tmr_nxt;
         rst_req                      <= req_nxt;
         {sys_rst_n, dclo_n, aclo_n}  <= pins(nxt);
         seq_busy                     <= (nxt != RUN);
         seq_state                    <= nxt;
      end
   end

endmodule

// File: tb/tb_qbus_reset_seq.sv
// Directed bench for qbus_reset_seq with short delays (DB_MAX=7, SYS 4, DCLO 8, ACLO 6, PFAIL 5).
// Checks are taken 1 time unit after each rising edge; edge counts are hand-derived.
module tb_qbus_reset_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] btn_n;
   logic [2:0] btn_q, btn_p;
   logic       sys_rst_n, dclo_n, aclo_n, seq_busy;
   logic [2:0] seq_state;
   logic [2:0] pins;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign pins = {sys_rst_n, dclo_n, aclo_n};

   qbus_reset_seq #(
      .NBTN(3), .RST_IDX(2), .PF_IDX(1), .DB_W(3), .TW(16),
      .SYS_DLY(4), .DCLO_DLY(8), .ACLO_DLY(6), .PFAIL_DLY(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .btn_q(btn_q), .btn_p(btn_p),
      .sys_rst_n(sys_rst_n), .dclo_n(dclo_n), .aclo_n(aclo_n),
      .seq_busy(seq_busy), .seq_state(seq_state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pins"},  pins,      3'b000);
      chk({tag, "_busy"},  seq_busy,  1'b1);
      chk({tag, "_state"}, seq_state, 3'd0);
      chk({tag, "_btnq"},  btn_q,     3'b000);
      chk({tag, "_btnp"},  btn_p,     3'b000);
   endtask

   // Call when the next rising edge is "edge 1" of a POR count with no RST held.
   task automatic powerup(input string tag);
      cyc(3);
      chk({tag, "_e3"},  pins, 3'b000);
      cyc(1);
      chk({tag, "_e4"},  pins, 3'b100);
      chk({tag, "_e4s"}, seq_state, 3'd1);
      cyc(7);
      chk({tag, "_e11"}, pins, 3'b100);
      cyc(1);
      chk({tag, "_e12"}, pins, 3'b110);
      chk({tag, "_e12s"}, seq_state, 3'd2);
      cyc(5);
      chk({tag, "_e17"}, pins, 3'b110);
      cyc(1);
      chk({tag, "_e18"}, pins, 3'b111);
      chk({tag, "_e18s"}, seq_state, 3'd3);
      chk({tag, "_e18b"}, seq_busy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int pulses;
      logic hi, dlow;

      rst_n = 1'b0;
      btn_n = 3'b111;
      cyc(3);
      chk_reset("rst");

      // Test 1: power-up order
      rst_n = 1'b1;
      powerup("t1");

      // Test 2: short glitch ignored, long press debounced with a single pulse
      pulses = 0;
      hi     = 1'b0;
      btn_n[0] = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         cyc(1);
         hi |= btn_q[0];
         pulses += int'(btn_p[0]);
      end
      btn_n[0] = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         cyc(1);
         hi |= btn_q[0];
         pulses += int'(btn_p[0]);
      end
      chk("t2_glitch_q", hi, 1'b0);
      btn_n[0] = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         cyc(1);
         pulses += int'(btn_p[0]);
         if (i == 8) chk("t2_q_e8", btn_q[0], 1'b0);
         if (i == 9) chk("t2_q_e9", btn_q[0], 1'b1);
      end
      btn_n[0] = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         cyc(1);
         pulses += int'(btn_p[0]);
         if (i == 8) chk("t2_rel_e8", btn_q[0], 1'b1);
         if (i == 9) chk("t2_rel_e9", btn_q[0], 1'b0);
      end
      chk("t2_pulses", pulses, 1);
      chk("t2_run", seq_state, 3'd3);

      // Test 4: power fail held 30 clks, DCLO never drops
      dlow = 1'b0;
      btn_n[1] = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         cyc(1);
         dlow |= ~dclo_n;
         if (i == 9)  chk("t4_pre", aclo_n, 1'b1);
         if (i == 10) chk("t4_acl", pins, 3'b110);
         if (i == 10) chk("t4_acl_s", seq_state, 3'd4);
      end
      chk("t4_hold", seq_state, 3'd4);
      btn_n[1] = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         cyc(1);
         dlow |= ~dclo_n;
         if (i == 9)  chk("t4_wait", seq_state, 3'd4);
         if (i == 10) chk("t4_dcl", seq_state, 3'd2);
         if (i == 15) chk("t4_e15", aclo_n, 1'b0);
         if (i == 16) chk("t4_e16", pins, 3'b111);
      end
      chk("t4_dclo", dlow, 1'b0);

      // Test 3: full reset from RUN via ACL, held in POR, then full power-up
      btn_n[2] = 1'b0;
      cyc(9);
      chk("t3_q", btn_q[2], 1'b1);
      chk("t3_pre", pins, 3'b111);
      cyc(1);
      chk("t3_acl", pins, 3'b110);
      chk("t3_acl_s", seq_state, 3'd4);
      cyc(4);
      chk("t3_acl_e14", pins, 3'b110);
      cyc(1);
      chk("t3_por", pins, 3'b000);
      chk("t3_por_s", seq_state, 3'd0);
      cyc(5);
      chk("t3_held", pins, 3'b000);
      btn_n[2] = 1'b1;
      cyc(9);
      chk("t3_rel_q", btn_q[2], 1'b0);
      powerup("t3");

      // Test 6: RST and PF debounce together, reset wins
      btn_n[2:1] = 2'b00;
      cyc(10);
      chk("t6_acl", seq_state, 3'd4);
      cyc(4);
      chk("t6_e14", seq_state, 3'd4);
      cyc(1);
      chk("t6_por", seq_state, 3'd0);
      chk("t6_por_p", pins, 3'b000);
      btn_n[2:1] = 2'b11;

      // Test 5a: RST debounces during DCL, straight to POR
      cyc(13);
      chk("t5_sys", seq_state, 3'd1);
      btn_n[2] = 1'b0;
      cyc(8);
      chk("t5_dcl", pins, 3'b110);
      cyc(1);
      chk("t5_dcl2", seq_state, 3'd2);
      cyc(1);
      chk("t5_por", seq_state, 3'd0);
      chk("t5_por_p", pins, 3'b000);
      btn_n[2] = 1'b1;
      cyc(9);
      powerup("t5");

      // Test 5b: rst_n asserted mid-ACL takes effect without a clock edge
      btn_n[1] = 1'b0;
      cyc(10);
      chk("t5b_acl", seq_state, 3'd4);
      cyc(2);
      rst_n = 1'b0;
      #1;
      chk_reset("t5b");
      btn_n[1] = 1'b1;
      #2;
      rst_n = 1'b1;
      powerup("t5c");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
